// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared register-file definitions for the write-back scheduler slice.
// Holds widths, the register index type and small mask helpers.
package aurora_rf_pkg;

   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      GRANT_NONE,
      GRANT_MEM,
      GRANT_ALU
   } grant_e;

   function automatic logic [NUM_REGS-1:0] idxToMask(input reg_idx_t idx);
      idxToMask      = '0;
      idxToMask[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Issue, producer-result and register-file write-port bundle of the scheduler.
// The slave modport is the scheduler side; the master modport is the surroundings.
interface regfile_wb_scheduler_if
   import aurora_rf_pkg::*;
#(
   parameter int XLEN = aurora_rf_pkg::XLEN
) ();

   logic                issue_valid_i;
   logic                issue_ready_o;
   reg_idx_t            issue_rs1_i;
   reg_idx_t            issue_rs2_i;
   reg_idx_t            issue_rd_i;
   logic                issue_rd_we_i;

   logic                alu_valid_i;
   logic                alu_ready_o;
   reg_idx_t            alu_rd_i;
   logic [XLEN-1:0]     alu_data_i;

   logic                mem_valid_i;
   logic                mem_ready_o;
   reg_idx_t            mem_rd_i;
   logic [XLEN-1:0]     mem_data_i;

   logic                rf_we_o;
   reg_idx_t            rf_waddr_o;
   logic [XLEN-1:0]     rf_wdata_o;
   logic [NUM_REGS-1:0] busy_o;

   modport slave (
      input  issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rd_i, issue_rd_we_i,
      input  alu_valid_i, alu_rd_i, alu_data_i,
      input  mem_valid_i, mem_rd_i, mem_data_i,
      output issue_ready_o, alu_ready_o, mem_ready_o,
      output rf_we_o, rf_waddr_o, rf_wdata_o, busy_o
   );

   modport master (
      output issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rd_i, issue_rd_we_i,
      output alu_valid_i, alu_rd_i, alu_data_i,
      output mem_valid_i, mem_rd_i, mem_data_i,
      input  issue_ready_o, alu_ready_o, mem_ready_o,
      input  rf_we_o, rf_waddr_o, rf_wdata_o, busy_o
   );

endinterface

// File: rtl/regfile_wb_scheduler_wb_scoreboard.sv
// Pending-write scoreboard: busy mask, set/clear on issue and write-back,
// and the RAW/WAW hazard check that gates instruction issue.
module wb_scoreboard
   import aurora_rf_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                issue_valid_i,
   input  reg_idx_t            issue_rs1_i,
   input  reg_idx_t            issue_rs2_i,
   input  reg_idx_t            issue_rd_i,
   input  logic                issue_rd_we_i,
   input  logic                rf_we_i,
   input  reg_idx_t            rf_waddr_i,
   output logic                issue_ready_o,
   output logic [NUM_REGS-1:0] busy_o
);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [NUM_REGS-1:0] clrMask, pendMask, setMask;
   logic                issueAccept;

   // A register being written back this cycle no longer blocks issue; the
   // register file forwards the write data to readers in the same cycle.
   always_comb begin
      clrMask       = rf_we_i ? idxToMask(rf_waddr_i) : '0;
      pendMask      = busy_q & ~clrMask;
      issue_ready_o = !pendMask[issue_rs1_i] && !pendMask[issue_rs2_i] &&
                      !(issue_rd_we_i && pendMask[issue_rd_i]);
      issueAccept   = issue_valid_i && issue_ready_o;
      setMask       = '0;
      if (issueAccept && issue_rd_we_i && (issue_rd_i != '0)) begin
         setMask = idxToMask(issue_rd_i);
      end
      busy_d        = pendMask | setMask;
      busy_d[0]     = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_o = busy_q;

   // Writing a register nobody is waiting for points at a producer bug upstream.
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      rf_we_i |-> busy_q[rf_waddr_i])
      else $error("write-back to non-busy register");

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back arbiter for the register-file write port with issue scoreboard.
// Define REGFILE_WB_ANTI_STARVE_EN to let a starved ALU force a grant over MEM.
module regfile_wb_scheduler
   import aurora_rf_pkg::*;
#(
   parameter int XLEN         = aurora_rf_pkg::XLEN,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   regfile_wb_scheduler_if.slave  wb
);

   logic            forceAlu;
   logic            aluReady, memReady;
   logic            aluAccept, memAccept;
   grant_e          grant;

   logic            rfWe_q, rfWe_d;
   reg_idx_t        rfWaddr_q, rfWaddr_d;
   logic [XLEN-1:0] rfWdata_q, rfWdata_d;

`ifdef REGFILE_WB_ANTI_STARVE_EN
   localparam logic [3:0] StarveLimitC = 4'(STARVE_LIMIT);

   logic [3:0] starveCnt_q, starveCnt_d;

   assign forceAlu = wb.alu_valid_i && (starveCnt_q == StarveLimitC);

   // Counts consecutive cycles the ALU waits; any cycle it is idle or served restarts it.
   always_comb begin
      starveCnt_d = '0;
      if (wb.alu_valid_i && !aluReady) begin
         starveCnt_d = (starveCnt_q == StarveLimitC) ? starveCnt_q : starveCnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starveCnt_q <= '0;
      end else begin
         starveCnt_q <= starveCnt_d;
      end
   end
`else
   assign forceAlu = 1'b0;
`endif

   assign memReady  = !forceAlu;
   assign aluReady  = !wb.mem_valid_i || forceAlu;
   assign memAccept = wb.mem_valid_i && memReady;
   assign aluAccept = wb.alu_valid_i && aluReady;

   always_comb begin
      grant = GRANT_NONE;
      if (memAccept) begin
         grant = GRANT_MEM;
      end else if (aluAccept) begin
         grant = GRANT_ALU;
      end
   end

   // Address and data hold on idle cycles so the write port only toggles on results.
   always_comb begin
      rfWe_d    = 1'b0;
      rfWaddr_d = rfWaddr_q;
      rfWdata_d = rfWdata_q;
      unique case (grant)
         GRANT_MEM: begin
            rfWe_d    = (wb.mem_rd_i != '0);
            rfWaddr_d = wb.mem_rd_i;
            rfWdata_d = wb.mem_data_i;
         end
         GRANT_ALU: begin
            rfWe_d    = (wb.alu_rd_i != '0);
            rfWaddr_d = wb.alu_rd_i;
            rfWdata_d = wb.alu_data_i;
         end
         default: begin
            rfWe_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rfWe_q    <= 1'b0;
         rfWaddr_q <= '0;
         rfWdata_q <= '0;
      end else begin
         rfWe_q    <= rfWe_d;
         rfWaddr_q <= rfWaddr_d;
         rfWdata_q <= rfWdata_d;
      end
   end

   assign wb.alu_ready_o = aluReady;
   assign wb.mem_ready_o = memReady;
   assign wb.rf_we_o     = rfWe_q;
   assign wb.rf_waddr_o  = rfWaddr_q;
   assign wb.rf_wdata_o  = rfWdata_q;

   wb_scoreboard u_scoreboard (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .issue_valid_i (wb.issue_valid_i),
      .issue_rs1_i   (wb.issue_rs1_i),
      .issue_rs2_i   (wb.issue_rs2_i),
      .issue_rd_i    (wb.issue_rd_i),
      .issue_rd_we_i (wb.issue_rd_we_i),
      .rf_we_i       (rfWe_q),
      .rf_waddr_i    (rfWaddr_q),
      .issue_ready_o (wb.issue_ready_o),
      .busy_o        (wb.busy_o)
   );

   assert property (@(posedge clk_i) (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 15))
      else $error("STARVE_LIMIT out of range");

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with a per-cycle reference model
// of arbitration, the write port and the busy mask.
module tb_regfile_wb_scheduler;
   import aurora_rf_pkg::*;

   localparam int StarveLimit = 4;

   typedef struct {
      logic        issueValid;
      reg_idx_t    rs1;
      reg_idx_t    rs2;
      reg_idx_t    rd;
      logic        rdWe;
      logic        aluValid;
      reg_idx_t    aluRd;
      logic [63:0] aluData;
      logic        memValid;
      reg_idx_t    memRd;
      logic [63:0] memData;
   } stim_t;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;

   always #5 clk_i = ~clk_i;

   regfile_wb_scheduler_if #(.XLEN(XLEN)) wb ();

   regfile_wb_scheduler #(.XLEN(XLEN), .STARVE_LIMIT(StarveLimit)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .wb     (wb)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state: one write-port slot, a per-register pending flag,
   // and the length of the ALU's current losing streak.
   bit          mBusy [NUM_REGS];
   bit          mWe;
   reg_idx_t    mAddr;
   logic [63:0] mData;
   int          mLoss;

   function automatic bit expForce();
`ifdef REGFILE_WB_ANTI_STARVE_EN
      return wb.alu_valid_i && (mLoss == StarveLimit);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit expMemReady();
      return !expForce();
   endfunction

   function automatic bit expAluReady();
      return !wb.mem_valid_i || expForce();
   endfunction

   function automatic bit stillPending(input reg_idx_t r);
      return mBusy[r] && !(mWe && (mAddr == r));
   endfunction

   function automatic bit expIssueReady();
      return !stillPending(wb.issue_rs1_i) && !stillPending(wb.issue_rs2_i) &&
             !(wb.issue_rd_we_i && stillPending(wb.issue_rd_i));
   endfunction

   function automatic logic [31:0] expBusy();
      logic [31:0] v;
      for (int r = 0; r < NUM_REGS; r++) v[r] = mBusy[r];
      return v;
   endfunction

   // Model advance on each edge using the inputs as they stood during the cycle.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int r = 0; r < NUM_REGS; r++) mBusy[r] <= 1'b0;
         mWe   <= 1'b0;
         mAddr <= '0;
         mData <= '0;
         mLoss <= 0;
      end else begin
         bit memWin, aluWin, issueAcc;
         memWin   = wb.mem_valid_i && expMemReady();
         aluWin   = !memWin && wb.alu_valid_i && expAluReady();
         issueAcc = wb.issue_valid_i && expIssueReady();
         if (memWin) begin
            mWe   <= (wb.mem_rd_i != 0);
            mAddr <= wb.mem_rd_i;
            mData <= wb.mem_data_i;
         end else if (aluWin) begin
            mWe   <= (wb.alu_rd_i != 0);
            mAddr <= wb.alu_rd_i;
            mData <= wb.alu_data_i;
         end else begin
            mWe   <= 1'b0;
         end
         mLoss <= (wb.alu_valid_i && !aluWin) ? ((mLoss + 1 > StarveLimit) ? StarveLimit : mLoss + 1) : 0;
         for (int r = 1; r < NUM_REGS; r++) begin
            if (issueAcc && wb.issue_rd_we_i && (wb.issue_rd_i == r)) mBusy[r] <= 1'b1;
            else if (mWe && (mAddr == r))                           mBusy[r] <= 1'b0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
      end
   endtask

   // Every cycle out of reset, all DUT outputs are set against the model.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         checkOutput("cmp rf_we",       64'(wb.rf_we_o),       64'(mWe));
         checkOutput("cmp rf_waddr",    64'(wb.rf_waddr_o),    64'(mAddr));
         checkOutput("cmp rf_wdata",    wb.rf_wdata_o,         mData);
         checkOutput("cmp busy",        64'(wb.busy_o),        64'(expBusy()));
         checkOutput("cmp issue_ready", 64'(wb.issue_ready_o), 64'(expIssueReady()));
         checkOutput("cmp alu_ready",   64'(wb.alu_ready_o),   64'(expAluReady()));
         checkOutput("cmp mem_ready",   64'(wb.mem_ready_o),   64'(expMemReady()));
      end
   end

   task automatic applyStimulus(input stim_t s);
      wb.issue_valid_i = s.issueValid;
      wb.issue_rs1_i   = s.rs1;
      wb.issue_rs2_i   = s.rs2;
      wb.issue_rd_i    = s.rd;
      wb.issue_rd_we_i = s.rdWe;
      wb.alu_valid_i   = s.aluValid;
      wb.alu_rd_i      = s.aluRd;
      wb.alu_data_i    = s.aluData;
      wb.mem_valid_i   = s.memValid;
      wb.mem_rd_i      = s.memRd;
      wb.mem_data_i    = s.memData;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      return s;
   endfunction

   initial begin
      stim_t s;
      string grants, expGrants;
      int memCnt, aluCnt;

      applyStimulus(idle());
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      checkOutput("reset busy", 64'(wb.busy_o), 64'h0);
      checkOutput("reset rf_we", 64'(wb.rf_we_o), 64'h0);

      // Single ALU result to a register issued beforehand, then a discarded rd=0 result.
      s = idle(); s.issueValid = 1; s.rd = 5; s.rdWe = 1;
      applyStimulus(s); #1;
      checkOutput("issue rd5 ready", 64'(wb.issue_ready_o), 64'h1);
      tick();
      s = idle(); s.aluValid = 1; s.aluRd = 5; s.aluData = 64'hDEAD_BEEF;
      applyStimulus(s); tick();
      checkOutput("alu5 we", 64'(wb.rf_we_o), 64'h1);
      checkOutput("alu5 addr", 64'(wb.rf_waddr_o), 64'h5);
      checkOutput("alu5 data", wb.rf_wdata_o, 64'hDEAD_BEEF);
      s.aluRd = 0; s.aluData = 64'h1234;
      applyStimulus(s); #1;
      checkOutput("alu0 ready", 64'(wb.alu_ready_o), 64'h1);
      tick();
      checkOutput("alu0 we", 64'(wb.rf_we_o), 64'h0);
      checkOutput("busy5 cleared", 64'(wb.busy_o[5]), 64'h0);

      // RAW stall on r7 until its write-back is on the port.
      s = idle(); s.issueValid = 1; s.rd = 7; s.rdWe = 1;
      applyStimulus(s); tick();
      checkOutput("busy7 set", 64'(wb.busy_o[7]), 64'h1);
      s = idle(); s.issueValid = 1; s.rs1 = 7;
      applyStimulus(s); #1;
      checkOutput("raw stall a", 64'(wb.issue_ready_o), 64'h0);
      tick();
      checkOutput("raw stall b", 64'(wb.issue_ready_o), 64'h0);
      s.aluValid = 1; s.aluRd = 7; s.aluData = 64'h77;
      applyStimulus(s); #1;
      checkOutput("raw stall c", 64'(wb.issue_ready_o), 64'h0);
      tick();
      s.aluValid = 0;
      applyStimulus(s); #1;
      checkOutput("raw bypass we", 64'(wb.rf_we_o), 64'h1);
      checkOutput("raw bypass ready", 64'(wb.issue_ready_o), 64'h1);
      tick();
      checkOutput("busy7 cleared", 64'(wb.busy_o[7]), 64'h0);

      // Set and clear of r9 on the same edge keeps it busy.
      s = idle(); s.issueValid = 1; s.rd = 9; s.rdWe = 1;
      applyStimulus(s); tick();
      s = idle(); s.aluValid = 1; s.aluRd = 9; s.aluData = 64'h99;
      applyStimulus(s); tick();
      s = idle(); s.issueValid = 1; s.rd = 9; s.rdWe = 1;
      applyStimulus(s); #1;
      checkOutput("waw ready", 64'(wb.issue_ready_o), 64'h1);
      tick();
      checkOutput("waw busy9", 64'(wb.busy_o[9]), 64'h1);
      s = idle(); s.aluValid = 1; s.aluRd = 9; s.aluData = 64'h999;
      applyStimulus(s); tick();
      applyStimulus(idle()); tick();
      checkOutput("busy9 cleared", 64'(wb.busy_o[9]), 64'h0);

      // Fill every register, then issue an all-zero-index instruction.
      for (int r = 1; r < NUM_REGS; r++) begin
         s = idle(); s.issueValid = 1; s.rd = reg_idx_t'(r); s.rdWe = 1;
         applyStimulus(s); tick();
      end
      applyStimulus(idle());
      checkOutput("busy full", 64'(wb.busy_o), 64'hFFFF_FFFE);
      s = idle(); s.issueValid = 1; s.rdWe = 1;
      applyStimulus(s); #1;
      checkOutput("zero idx ready", 64'(wb.issue_ready_o), 64'h1);
      tick();
      checkOutput("busy0 zero", 64'(wb.busy_o[0]), 64'h0);

      // Both producers valid for ten cycles.
      grants = ""; memCnt = 0; aluCnt = 0;
      for (int i = 0; i < 10; i++) begin
         s = idle();
         s.memValid = 1; s.memRd = reg_idx_t'(1 + memCnt); s.memData = 64'h1000 + 64'(i);
         s.aluValid = 1; s.aluRd = reg_idx_t'(20 + aluCnt); s.aluData = 64'h2000 + 64'(i);
         applyStimulus(s); #1;
         if (wb.alu_ready_o) begin
            grants = {grants, "A"}; aluCnt++;
         end else if (wb.mem_ready_o) begin
            grants = {grants, "M"}; memCnt++;
         end else begin
            grants = {grants, "-"};
         end
         tick();
      end
`ifdef REGFILE_WB_ANTI_STARVE_EN
      expGrants = "MMMMAMMMMA";
      checkOutput("last grant addr", 64'(wb.rf_waddr_o), 64'd21);
      checkOutput("last grant data", wb.rf_wdata_o, 64'h2009);
`else
      expGrants = "MMMMMMMMMM";
      checkOutput("last grant addr", 64'(wb.rf_waddr_o), 64'd10);
      checkOutput("last grant data", wb.rf_wdata_o, 64'h1009);
`endif
      checks++;
      if (grants != expGrants) begin
         failures++;
         $display("[TB] FAIL grant sequence: got %s, expected %s", grants, expGrants);
      end

      // Asynchronous reset while traffic is still presented.
      #2 rst_ni = 1'b0;
      #1;
      checkOutput("async rst we", 64'(wb.rf_we_o), 64'h0);
      checkOutput("async rst addr", 64'(wb.rf_waddr_o), 64'h0);
      checkOutput("async rst data", wb.rf_wdata_o, 64'h0);
      checkOutput("async rst busy", 64'(wb.busy_o), 64'h0);
      applyStimulus(idle());
      tick();
      rst_ni = 1'b1;
      tick();
      checkOutput("post rst busy", 64'(wb.busy_o), 64'h0);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
